// File: rtl/spi_seq.sv
// spi_seq: round-robin sequencer that runs byte transfers from two requesters through a register-mapped SPI core
module spi_seq #(
  parameter int NREQ = 2,
  parameter logic [7:0] TMO = 8'd255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      sel0,
  input  logic [2:0]      sel1,
  input  logic [2:0]      div0,
  input  logic [2:0]      div1,
  input  logic [7:0]      txd0,
  input  logic [7:0]      txd1,
  input  logic [NREQ-1:0] txv_i,
  input  logic [NREQ-1:0] txl_i,
  output logic [NREQ-1:0] txr_o,
  output logic [7:0]      rxd_o,
  output logic [NREQ-1:0] rxv_o,
  output logic [NREQ-1:0] gnt_o,
  output logic            err_o,
  output logic [7:0]      m_addr,
  output logic [15:0]     m_dw,
  input  logic [15:0]     m_dr,
  output logic            m_uds,
  output logic            m_lds,
  output logic            m_rw,
  input  logic            m_ack
);
  typedef enum logic [3:0] {IDLE, CFG, TXW, GAP, POLL, RXR, DLV, END, ERR} state_t;
  state_t state, nxt;
  logic cur, g, ph, tx_last, strb;
  logic [1:0] oh;
  logic [2:0] sel_q, div_q;
  logic [7:0] tx_byte, wd;
  logic unused_ok;
  assign unused_ok = ^m_dr[7:1];
  assign m_addr = 8'd0;
  assign strb = m_uds | m_lds;
  assign oh = cur ? 2'b10 : 2'b01;
  // cur holds the last grant, so on a tie the other port wins
  assign g = req_i[1] & (~req_i[0] | ~cur);
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req_i ? CFG : IDLE;
      CFG:     nxt = m_ack ? TXW : CFG;
      TXW:     nxt = (ph && m_ack) ? GAP : TXW;
      GAP:     nxt = POLL;
      POLL:    nxt = !m_ack ? POLL : m_dr[0] ? GAP : RXR;
      RXR:     nxt = (ph && m_ack) ? DLV : RXR;
      DLV:     nxt = tx_last ? END : TXW;
      END:     nxt = m_ack ? IDLE : END;
      default: nxt = state;
    endcase
    if (strb && !m_ack && wd == TMO - 8'd1) nxt = ERR;
  end
  // ph splits TXW and RXR into an idle half and a strobed half, keeping strobes low after every ack
  always_comb begin
    m_lds = state == CFG || state == POLL || state == END;
    m_uds = ph && (state == TXW || state == RXR);
    m_rw = !(state == CFG || state == END || (state == TXW && ph));
    m_dw = state == CFG ? {9'd0, sel_q, div_q, 1'b0} :
           state == END ? {12'd0, div_q, 1'b0} :
           (state == TXW && ph) ? {tx_byte, 8'd0} : 16'd0;
    gnt_o = (state == IDLE || state == ERR) ? 2'b00 : oh;
    txr_o = (state == TXW && !ph && txv_i[cur]) ? oh : 2'b00;
    rxv_o = state == DLV ? oh : 2'b00;
    err_o = state == ERR;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      cur <= 1'b1;
      ph <= 1'b0;
      tx_byte <= 8'd0;
      tx_last <= 1'b0;
      wd <= 8'd0;
      rxd_o <= 8'd0;
      sel_q <= 3'd0;
      div_q <= 3'd0;
    end else begin
      wd <= (m_ack || !strb) ? 8'd0 : wd + 8'd1;
      ph <= (nxt != state) ? 1'b0 : (state == TXW) ? (ph | txv_i[cur]) : (state == RXR);
      if (state == IDLE && |req_i) begin
        cur <= g;
        sel_q <= g ? sel1 : sel0;
        div_q <= g ? div1 : div0;
      end
      if (|txr_o) begin
        tx_byte <= cur ? txd1 : txd0;
        tx_last <= txl_i[cur];
      end
      if (state == RXR && ph && m_ack) rxd_o <= m_dr[15:8];
    end
endmodule

// File: tb/tb_spi_seq.sv
// tb_spi_seq: scoreboard bench for spi_seq with an SPI-core bus model that returns tx^0x99
module tb_spi_seq;
  logic clk = 0, reset_n = 0;
  logic rq0 = 0, rq1 = 0, tv0 = 0, tv1 = 0, tl0 = 0, tl1 = 0;
  logic [2:0] sel0 = 0, sel1 = 0, div0 = 0, div1 = 0;
  logic [7:0] txd0 = 0, txd1 = 0;
  logic [1:0] req_i, txv_i, txl_i, txr_o, rxv_o, gnt_o;
  logic [7:0] rxd_o, m_addr;
  logic [15:0] m_dw;
  logic [15:0] m_dr = 0;
  logic m_uds, m_lds, m_rw, err_o;
  logic m_ack = 0;
  int n_chk = 0, n_pass = 0, cyc = 0, uds_rise = 0, g1_rise = 0, end0_cyc = 0;
  int busy_n = 1, busy_left = 0;
  logic noack = 0, prev_ack = 0, uds_d = 0, g1_d = 0;
  logic [7:0] last_tx = 0;
  logic [18:0] exp_bus[$];
  logic [9:0] exp_rx[$];
  assign req_i = {rq1, rq0};
  assign txv_i = {tv1, tv0};
  assign txl_i = {tl1, tl0};
  spi_seq dut (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .sel0(sel0), .sel1(sel1), .div0(div0), .div1(div1),
    .txd0(txd0), .txd1(txd1), .txv_i(txv_i), .txl_i(txl_i), .txr_o(txr_o), .rxd_o(rxd_o), .rxv_o(rxv_o),
    .gnt_o(gnt_o), .err_o(err_o), .m_addr(m_addr), .m_dw(m_dw), .m_dr(m_dr), .m_uds(m_uds), .m_lds(m_lds),
    .m_rw(m_rw), .m_ack(m_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at cycle %0d", tag, got, exp, cyc);
  endtask
  function automatic logic [18:0] acc(input logic u, input logic l, input logic rw, input logic [15:0] dw);
    return {u, l, rw, dw};
  endfunction
  // bus monitor and core model: acks every strobe in its first cycle unless noack blocks a TX write
  always @(negedge clk) begin : mon
    logic [18:0] a;
    cyc++;
    if (!reset_n) begin
      m_ack = 0;
      prev_ack = 0;
      uds_d = 0;
      g1_d = 0;
    end else begin
      if (prev_ack) chk("idle_after_ack", {31'd0, m_uds | m_lds}, 0);
      if (m_uds | m_lds) chk("one_strobe", {31'd0, m_uds & m_lds}, 0);
      if (|gnt_o) chk("gnt_onehot", {31'd0, $onehot(gnt_o)}, 1);
      if (|(txr_o | rxv_o)) chk("pulse_port", {30'd0, (txr_o | rxv_o) & ~gnt_o}, 0);
      if (m_uds && !uds_d) uds_rise = cyc;
      if (gnt_o[1] && !g1_d) g1_rise = cyc;
      if (|rxv_o) chk("rx", {22'd0, rxv_o, rxd_o}, {22'd0, exp_rx.size() > 0 ? exp_rx.pop_front() : 10'h0});
      m_ack = (m_uds | m_lds) && !(noack && m_uds && !m_rw);
      if (m_ack) begin
        a = {m_uds, m_lds, m_rw, m_dw};
        chk("bus", {13'd0, a}, {13'd0, exp_bus.size() > 0 ? exp_bus.pop_front() : 19'h0});
        if (m_uds && m_rw) m_dr = {last_tx ^ 8'h99, 8'h00};
        else if (m_rw) begin
          m_dr = {15'd0, busy_left != 0};
          if (busy_left > 0) busy_left--;
        end else if (m_uds) begin
          last_tx = m_dw[15:8];
          busy_left = busy_n;
        end else if (m_dw[6:4] == 3'd0 && gnt_o[0]) end0_cyc = cyc;
      end
      prev_ack = m_ack;
      uds_d = m_uds;
      g1_d = gnt_o[1];
    end
  end
  task automatic set_tx(input int p, input logic v, input logic [7:0] d, input logic l);
    if (p == 1) begin tv1 = v; txd1 = d; tl1 = l; end
    else begin tv0 = v; txd0 = d; tl0 = l; end
  endtask
  task automatic set_req(input int p, input logic v);
    if (p == 1) rq1 = v;
    else rq0 = v;
  endtask
  task automatic push_exp(input int p, input logic [2:0] s, input logic [2:0] d, input logic [23:0] b,
                          input int n, input int busy);
    exp_bus.push_back(acc(0, 1, 0, {9'd0, s, d, 1'b0}));
    for (int i = 0; i < n; i++) begin
      exp_bus.push_back(acc(1, 0, 0, {b[8*i +: 8], 8'h00}));
      repeat (busy + 1) exp_bus.push_back(acc(0, 1, 1, 16'h0));
      exp_bus.push_back(acc(1, 0, 1, 16'h0));
      exp_rx.push_back({p == 1 ? 2'b10 : 2'b01, b[8*i +: 8] ^ 8'h99});
    end
    exp_bus.push_back(acc(0, 1, 0, {12'd0, d, 1'b0}));
  endtask
  task automatic feed(input int p, input logic [23:0] b, input int n);
    int t;
    @(negedge clk);
    set_req(p, 1'b1);
    for (int i = 0; i < n; i++) begin
      set_tx(p, 1'b1, b[8*i +: 8], i == n - 1);
      t = 0;
      #1;
      while (!txr_o[p] && t < 3000) begin @(negedge clk); #1; t++; end
      chk("txr_wait", {31'd0, t < 3000}, 1);
      @(negedge clk);
      set_tx(p, 1'b0, 8'h00, 1'b0);
      t = 0;
      #1;
      while (!rxv_o[p] && t < 3000) begin @(negedge clk); #1; t++; end
      chk("rxv_wait", {31'd0, t < 3000}, 1);
    end
    set_req(p, 1'b0);
    t = 0;
    while (gnt_o[p] && t < 100) begin @(negedge clk); #1; t++; end
    chk("gnt_drop", {31'd0, gnt_o[p]}, 0);
  endtask
  task automatic drained(input string tag);
    chk(tag, exp_bus.size() + exp_rx.size(), 0);
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"}, {21'd0, gnt_o, txr_o, rxv_o, err_o, m_uds, m_lds, m_rw}, 32'h1);
    chk({tag, "_data"}, {rxd_o, m_dw, m_addr}, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    exp_bus.delete();
    exp_rx.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end
  initial begin
    int t;
    repeat (3) @(negedge clk);
    #1 chk_rst("reset");
    @(negedge clk) reset_n = 1;
    sel0 = 3'd1; div0 = 3'd2; busy_n = 1;
    exp_bus.push_back(acc(0, 1, 0, 16'h0014));
    exp_bus.push_back(acc(1, 0, 0, 16'hA500));
    repeat (2) exp_bus.push_back(acc(0, 1, 1, 16'h0));
    exp_bus.push_back(acc(1, 0, 1, 16'h0));
    exp_bus.push_back(acc(0, 1, 0, 16'h0004));
    exp_rx.push_back({2'b01, 8'h3C});
    feed(0, 24'h0000A5, 1);
    drained("single_drain");
    do_reset();
    sel0 = 3'd1; div0 = 3'd1; sel1 = 3'd2; div1 = 3'd3;
    push_exp(0, 3'd1, 3'd1, 24'h11, 1, 1);
    push_exp(1, 3'd2, 3'd3, 24'h22, 1, 1);
    fork
      feed(0, 24'h000011, 1);
      feed(1, 24'h000022, 1);
    join
    drained("dual_drain");
    chk("g1_after_end0", {31'd0, g1_rise > end0_cyc && end0_cyc != 0}, 1);
    sel1 = 3'd3; div1 = 3'd7;
    push_exp(1, 3'd3, 3'd7, 24'h030201, 3, 1);
    feed(1, 24'h030201, 3);
    drained("burst_drain");
    busy_n = 5; sel0 = 3'd2; div0 = 3'd0;
    push_exp(0, 3'd2, 3'd0, 24'h5A, 1, 5);
    feed(0, 24'h00005A, 1);
    drained("busy_drain");
    busy_n = 20; sel1 = 3'd1; div1 = 3'd1;
    push_exp(1, 3'd1, 3'd1, 24'h66, 1, 20);
    @(negedge clk);
    rq1 = 1;
    set_tx(1, 1'b1, 8'h66, 1'b1);
    t = 0;
    #1;
    while (!(m_lds && m_rw) && t < 500) begin @(negedge clk); #1; t++; end
    chk("poll_wait", {31'd0, t < 500}, 1);
    reset_n = 0;
    @(posedge clk);
    #1 chk_rst("poll_rst");
    rq1 = 0;
    set_tx(1, 1'b0, 8'h00, 1'b0);
    exp_bus.delete();
    exp_rx.delete();
    @(negedge clk) reset_n = 1;
    busy_n = 1; sel0 = 3'd1; div0 = 3'd2;
    push_exp(0, 3'd1, 3'd2, 24'hC3, 1, 1);
    feed(0, 24'h0000C3, 1);
    drained("after_rst_drain");
    noack = 1; sel0 = 3'd1; div0 = 3'd1;
    exp_bus.push_back(acc(0, 1, 0, 16'h0012));
    @(negedge clk);
    rq0 = 1;
    set_tx(0, 1'b1, 8'h77, 1'b1);
    t = 0;
    #1;
    while (!err_o && t < 1000) begin @(negedge clk); #1; t++; end
    chk("wd_wait", {31'd0, t < 1000}, 1);
    chk("wd_delay", cyc - uds_rise, 255);
    chk("wd_outs", {27'd0, gnt_o, m_uds, m_lds, err_o}, 1);
    rq0 = 0;
    set_tx(0, 1'b0, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    #1 chk("err_sticky", {31'd0, err_o}, 1);
    drained("wd_drain");
    noack = 0;
    @(negedge clk) reset_n = 0;
    @(posedge clk);
    #1 chk_rst("final_rst");
    @(negedge clk) reset_n = 1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
